// File: rtl/raster_tx.sv
// Raster stream transmitter: pulls pixels from a valid/ready source and drives
// hstr/href/hend/vstr/vend frames. Optional pattern source: RASTER_TX_PATGEN_EN.
module raster_tx #(
  parameter int unsigned DBUF_DW = 8,
  parameter int unsigned HCNT_W  = 12,
  parameter int unsigned VCNT_W  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic [HCNT_W-1:0]  i_hsize,
  input  logic [VCNT_W-1:0]  i_vsize,
  input  logic [HCNT_W-1:0]  i_hblank,
  input  logic [VCNT_W-1:0]  i_vblank,
  input  logic               i_pat_sel,
  input  logic [DBUF_DW-1:0] i_pix_data,
  input  logic               i_pix_vld,
  output logic               o_pix_rdy,
  output logic [DBUF_DW-1:0] o_data,
  output logic               o_href,
  output logic               o_hstr,
  output logic               o_hend,
  output logic               o_vstr,
  output logic               o_vend,
  output logic               o_unf,
  output logic               o_cfg_err
);

  localparam logic [HCNT_W-1:0] HOne = HCNT_W'(1);
  localparam logic [VCNT_W-1:0] VOne = VCNT_W'(1);
  localparam logic [HCNT_W:0]   BOne = (HCNT_W + 1)'(1);

  typedef enum logic [2:0] {StIdle, StFstr, StAct, StHblk, StVblk} state_e;

  state_e              state_q, state_d;
  logic [HCNT_W-1:0]   hsize_q, hblank_q, col_q, col_d;
  logic [VCNT_W-1:0]   vsize_q, vblank_q, line_q, line_d, vline_q, vline_d;
  logic [HCNT_W:0]     bcnt_q, bcnt_d;
  logic                load, frame_end, cfg_bad, cfg_err_d;
  logic                col_last, line_last, hblk_last, vblk_last, vline_last;
  logic                act, pat;
  logic [DBUF_DW-1:0]  data_q, data_d;
  logic                href_d, hstr_d, hend_d, vstr_d, vend_d, unf_d, unf_set;
  logic                href_q, hstr_q, hend_q, vstr_q, vend_q, unf_q, cfg_err_q;

  assign cfg_bad    = (i_hsize == '0) || (i_vsize == '0);
  assign col_last   = (col_q == hsize_q - HOne);
  assign line_last  = (line_q == vsize_q - VOne);
  assign hblk_last  = (bcnt_q == {1'b0, hblank_q} - BOne);
  // VBLK line length is hsize+hblank; one extra bit keeps the sum from wrapping
  assign vblk_last  = (bcnt_q == {1'b0, hsize_q} + {1'b0, hblank_q} - BOne);
  assign vline_last = (vline_q == vblank_q - VOne);
  assign act        = (state_q == StAct);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      col_q    <= '0;
      line_q   <= '0;
      bcnt_q   <= '0;
      vline_q  <= '0;
      hsize_q  <= '0;
      vsize_q  <= '0;
      hblank_q <= '0;
      vblank_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      bcnt_q  <= bcnt_d;
      vline_q <= vline_d;
      if (load) begin
        hsize_q  <= i_hsize;
        vsize_q  <= i_vsize;
        hblank_q <= i_hblank;
        vblank_q <= i_vblank;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    line_d    = line_q;
    bcnt_d    = bcnt_q;
    vline_d   = vline_q;
    frame_end = 1'b0;
    load      = 1'b0;
    cfg_err_d = 1'b0;
    unique case (state_q)
      StIdle: frame_end = 1'b1;
      StFstr: begin
        state_d = StAct;
        col_d   = '0;
        line_d  = '0;
      end
      StAct: begin
        if (col_last) begin
          col_d  = '0;
          bcnt_d = '0;
          if (hblank_q != '0) begin
            state_d = StHblk;
          end else if (!line_last) begin
            line_d = line_q + VOne;
          end else if (vblank_q != '0) begin
            state_d = StVblk;
            vline_d = '0;
          end else begin
            frame_end = 1'b1;
          end
        end else begin
          col_d = col_q + HOne;
        end
      end
      StHblk: begin
        if (hblk_last) begin
          bcnt_d = '0;
          if (!line_last) begin
            state_d = StAct;
            line_d  = line_q + VOne;
            col_d   = '0;
          end else if (vblank_q != '0) begin
            state_d = StVblk;
            vline_d = '0;
          end else begin
            frame_end = 1'b1;
          end
        end else begin
          bcnt_d = bcnt_q + BOne;
        end
      end
      StVblk: begin
        if (vblk_last) begin
          bcnt_d = '0;
          if (vline_last) frame_end = 1'b1;
          else            vline_d   = vline_q + VOne;
        end else begin
          bcnt_d = bcnt_q + BOne;
        end
      end
      default: state_d = StIdle;
    endcase
    // Idle and end-of-frame share one decision: relatch config or park
    if (frame_end) begin
      load = i_en;
      if (i_en && !cfg_bad) begin
        state_d = StFstr;
      end else begin
        state_d   = StIdle;
        cfg_err_d = i_en;
      end
    end
  end

`ifdef RASTER_TX_PATGEN_EN
  logic pat_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pat_q <= 1'b0;
    else if (load) pat_q <= i_pat_sel;
  end
  assign pat = pat_q;
`else
  logic unused_pat_sel;
  assign unused_pat_sel = i_pat_sel;
  assign pat = 1'b0;
`endif

  always_comb begin
    href_d  = act;
    hstr_d  = act && (col_q == '0);
    hend_d  = act && col_last;
    vend_d  = act && col_last && line_last;
    vstr_d  = (state_q == StFstr);
    data_d  = data_q;
    unf_set = 1'b0;
    if (act) begin
`ifdef RASTER_TX_PATGEN_EN
      if (pat)            data_d  = col_q[DBUF_DW-1:0] ^ line_q[DBUF_DW-1:0];
      else if (i_pix_vld) data_d  = i_pix_data;
      else                unf_set = 1'b1;
`else
      if (i_pix_vld) data_d  = i_pix_data;
      else           unf_set = 1'b1;
`endif
    end
    unf_d     = unf_set | (unf_q & ~vstr_d);
    o_pix_rdy = act & ~pat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      href_q    <= 1'b0;
      hstr_q    <= 1'b0;
      hend_q    <= 1'b0;
      vstr_q    <= 1'b0;
      vend_q    <= 1'b0;
      unf_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      href_q    <= href_d;
      hstr_q    <= hstr_d;
      hend_q    <= hend_d;
      vstr_q    <= vstr_d;
      vend_q    <= vend_d;
      unf_q     <= unf_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign o_data    = data_q;
  assign o_href    = href_q;
  assign o_hstr    = hstr_q;
  assign o_hend    = hend_q;
  assign o_vstr    = vstr_q;
  assign o_vend    = vend_q;
  assign o_unf     = unf_q;
  assign o_cfg_err = cfg_err_q;

endmodule

// File: tb/tb_raster_tx.sv
// Scoreboard bench for raster_tx: expected beats are queued per frame and
// popped by a monitor on every o_href cycle.
module tb_raster_tx;
  localparam int DW = 8;
  localparam int HW = 12;
  localparam int VW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_en = 1'b0;
  logic [HW-1:0] i_hsize = '0;
  logic [VW-1:0] i_vsize = '0;
  logic [HW-1:0] i_hblank = '0;
  logic [VW-1:0] i_vblank = '0;
  logic          i_pat_sel = 1'b0;
  logic [DW-1:0] i_pix_data = '0;
  logic          i_pix_vld = 1'b0;
  logic          o_pix_rdy, o_href, o_hstr, o_hend, o_vstr, o_vend, o_unf, o_cfg_err;
  logic [DW-1:0] o_data;

  raster_tx #(.DBUF_DW(DW), .HCNT_W(HW), .VCNT_W(VW)) dut (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_hsize(i_hsize), .i_vsize(i_vsize),
    .i_hblank(i_hblank), .i_vblank(i_vblank), .i_pat_sel(i_pat_sel),
    .i_pix_data(i_pix_data), .i_pix_vld(i_pix_vld), .o_pix_rdy(o_pix_rdy),
    .o_data(o_data), .o_href(o_href), .o_hstr(o_hstr), .o_hend(o_hend),
    .o_vstr(o_vstr), .o_vend(o_vend), .o_unf(o_unf), .o_cfg_err(o_cfg_err)
  );

  initial forever #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] sb[$];
  int          vstr_q[$];
  int          beat_cyc[$];
  logic        unf_at[$];
  logic        unf_before[$];
  int          cfg_err_cnt = 0;
  int          rdy_hi_cnt = 0;
  int          pix_val = 1;
  int          rdy_cnt = 0;
  int          drop_idx = -1;
  int          model_val = 1;
  logic [DW-1:0] model_prev = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return 32'({o_pix_rdy, o_data, o_href, o_hstr, o_hend, o_vstr, o_vend, o_unf, o_cfg_err});
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Upstream source: always valid except on the beat index drop_idx
  initial forever begin
    @(negedge clk);
    if (o_pix_rdy) begin
      rdy_hi_cnt++;
      i_pix_vld  = (rdy_cnt != drop_idx);
      i_pix_data = DW'(pix_val);
      if (i_pix_vld) pix_val++;
      rdy_cnt++;
    end else begin
      i_pix_vld  = 1'b1;
      i_pix_data = DW'(pix_val);
    end
  end

  initial begin
    logic        unf_prev;
    logic [31:0] exp;
    unf_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_vstr) begin
        vstr_q.push_back(cyc);
        unf_at.push_back(o_unf);
        unf_before.push_back(unf_prev);
      end
      if (o_cfg_err) cfg_err_cnt++;
      if (o_href) begin
        beat_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check("sb_extra_beat", 32'(sb.size()), 32'd1);
        end else begin
          exp = sb.pop_front();
          check("beat", 32'({o_data, o_hstr, o_hend, o_vend}), exp);
        end
      end else if (o_hstr || o_hend || o_vend) begin
        check("flag_outside_href", 32'({o_hstr, o_hend, o_vend}), 32'd0);
      end
      unf_prev = o_unf;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic cfg(input int hs, input int vs, input int hb, input int vb);
    i_hsize  = HW'(hs);
    i_vsize  = VW'(vs);
    i_hblank = HW'(hb);
    i_vblank = VW'(vb);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_en  = 1'b0;
    i_pat_sel = 1'b0;
    tick(2);
    sb.delete(); vstr_q.delete(); beat_cyc.delete(); unf_at.delete(); unf_before.delete();
    cfg_err_cnt = 0; rdy_hi_cnt = 0; pix_val = 1; rdy_cnt = 0; drop_idx = -1;
    model_val = 1; model_prev = '0;
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic push_frame(input int hs, input int vs, input int drop, input bit pat);
    int k = 0;
    for (int l = 0; l < vs; l++) begin
      for (int c = 0; c < hs; c++) begin
        logic [DW-1:0] d;
        if (pat)            d = DW'(c ^ l);
        else if (k == drop) d = model_prev;
        else begin
          d = DW'(model_val);
          model_val++;
        end
        model_prev = d;
        sb.push_back(32'({d, c == 0, c == hs - 1, (c == hs - 1) && (l == vs - 1)}));
        k++;
      end
    end
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (sb.size() != 0 && t < budget) begin
      tick(1);
      t++;
    end
    check("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  // Hold i_en until n more frame starts are seen, then drop it mid-frame
  task automatic run_frames(input int n, input int budget);
    int target = vstr_q.size() + n;
    int t = 0;
    i_en = 1'b1;
    while (vstr_q.size() < target && t < budget) begin
      tick(1);
      t++;
    end
    i_en = 1'b0;
    check("vstr_count", 32'(vstr_q.size()), 32'(target));
    drain(budget);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    // Basic frame with blanking, two frames back to back
    do_reset();
    check("reset_outputs", outs_vec(), 32'd0);
    cfg(4, 2, 3, 1);
    push_frame(4, 2, -1, 0);
    push_frame(4, 2, -1, 0);
    run_frames(2, 200);
    check("t1_vstr_period", 32'(vstr_q[1] - vstr_q[0]), 32'd22);
    check("t1_href_latency", 32'(beat_cyc[0] - vstr_q[0]), 32'd1);
    check("t1_line_len", 32'(beat_cyc[3] - beat_cyc[0]), 32'd3);
    check("t1_hblank_gap", 32'(beat_cyc[4] - beat_cyc[3]), 32'd4);
    tick(40);
    check("t1_stopped", 32'(vstr_q.size()), 32'd2);
    check("t1_no_unf", 32'(o_unf), 32'd0);

    // Underflow on the 3rd pixel of line 0
    do_reset();
    cfg(4, 2, 3, 1);
    drop_idx = 2;
    push_frame(4, 2, 2, 0);
    push_frame(4, 2, -1, 0);
    run_frames(2, 200);
    check("t2_unf_first_vstr", 32'(unf_at[0]), 32'd0);
    check("t2_unf_held", 32'(unf_before[1]), 32'd1);
    check("t2_unf_cleared", 32'(unf_at[1]), 32'd0);
    check("t2_unf_final", 32'(o_unf), 32'd0);

    // Minimal 1x1 frame, no blanking
    do_reset();
    cfg(1, 1, 0, 0);
    repeat (3) push_frame(1, 1, -1, 0);
    run_frames(3, 50);
    check("t3_period_a", 32'(vstr_q[1] - vstr_q[0]), 32'd2);
    check("t3_period_b", 32'(vstr_q[2] - vstr_q[1]), 32'd2);
    tick(10);
    check("t3_stopped", 32'(vstr_q.size()), 32'd3);

    // Enable drop and hsize change mid-frame
    do_reset();
    cfg(4, 3, 2, 1);
    push_frame(4, 3, -1, 0);
    i_en = 1'b1;
    t = 0;
    while (beat_cyc.size() < 5 && t < 100) begin
      tick(1);
      t++;
    end
    i_en = 1'b0;
    i_hsize = HW'(2);
    drain(200);
    tick(40);
    check("t4_one_frame", 32'(vstr_q.size()), 32'd1);
    push_frame(2, 3, -1, 0);
    run_frames(1, 200);
    check("t4_new_hsize_gap", 32'(beat_cyc[14] - beat_cyc[13]), 32'd3);

    // Illegal config
    do_reset();
    cfg(0, 2, 1, 1);
    i_en = 1'b1;
    tick(1);
    i_en = 1'b0;
    tick(5);
    check("t5_cfg_err_h", 32'(cfg_err_cnt), 32'd1);
    cfg(4, 0, 1, 1);
    i_en = 1'b1;
    tick(1);
    i_en = 1'b0;
    tick(5);
    check("t5_cfg_err_v", 32'(cfg_err_cnt), 32'd2);
    check("t5_no_vstr", 32'(vstr_q.size()), 32'd0);

    // Reset mid-ACT, then underflow on first beat shows reset data
    cfg(4, 2, 1, 1);
    push_frame(4, 2, -1, 0);
    i_en = 1'b1;
    t = 0;
    while (beat_cyc.size() < 2 && t < 100) begin
      tick(1);
      t++;
    end
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", outs_vec(), 32'd0);
    do_reset();
    tick(10);
    check("t6_idle_after_reset", 32'(vstr_q.size()), 32'd0);
    cfg(2, 1, 1, 1);
    drop_idx = 0;
    push_frame(2, 1, 0, 0);
    run_frames(1, 50);

`ifdef RASTER_TX_PATGEN_EN
    do_reset();
    cfg(4, 2, 1, 1);
    i_pat_sel = 1'b1;
    push_frame(4, 2, -1, 1);
    run_frames(1, 100);
    check("t7_rdy_low", 32'(rdy_hi_cnt), 32'd0);
    check("t7_no_unf", 32'(o_unf), 32'd0);
`endif

    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
